// File: rtl/dct_pkg.sv
// Shared constants for the 2-D DCT sequencer: FSM encodings, pass encodings
// and the default block geometry.
package dct_pkg;
  localparam int DCT_N  = 8;
  localparam int IDX_W  = $clog2(DCT_N);
  localparam int ADDR_W = 2 * IDX_W;

  localparam logic PASS_ROW = 1'b0;
  localparam logic PASS_COL = 1'b1;

  typedef logic [2:0] state_t;
  localparam state_t IDLE      = 3'd0;
  localparam state_t FILL      = 3'd1;
  localparam state_t ROW_ISSUE = 3'd2;
  localparam state_t ROW_WAIT  = 3'd3;
  localparam state_t COL_ISSUE = 3'd4;
  localparam state_t COL_WAIT  = 3'd5;
  localparam state_t DRAIN     = 3'd6;
endpackage

// File: rtl/dct_block_seq_if.sv
// Pixel intake, block-buffer write, DCT engine control and block handoff
// signals of the sequencer. The master side is the sequencer itself.
interface dct_block_seq_if import dct_pkg::*; #(
  parameter int N     = DCT_N,
  parameter int CNT_W = 16
);
  localparam int IW = $clog2(N);

  logic              pix_valid;
  logic              pix_ready;
  logic              buf_we;
  logic [2*IW-1:0]   buf_waddr;
  logic              eng_start;
  logic              eng_pass;
  logic [IW-1:0]     eng_idx;
  logic              eng_done;
  logic              blk_valid;
  logic              blk_ready;
  logic [CNT_W-1:0]  blk_count;
  logic              err;
  logic              err_clr;

  modport master (
    input  pix_valid, eng_done, blk_ready, err_clr,
    output pix_ready, buf_we, buf_waddr, eng_start, eng_pass, eng_idx,
           blk_valid, blk_count, err
  );

  modport slave (
    output pix_valid, eng_done, blk_ready, err_clr,
    input  pix_ready, buf_we, buf_waddr, eng_start, eng_pass, eng_idx,
           blk_valid, blk_count, err
  );
endinterface

// File: rtl/dct_wait_timer.sv
// Engine watchdog: cleared while a vector is issued, counts wait cycles and
// flags expiry on the cycle the count would reach TIMEOUT-1.
module dct_wait_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == W'(TIMEOUT - 2));
endmodule

// File: rtl/dct_block_seq.sv
// 2-D DCT sequencer: fills an NxN block buffer, runs N row then N column
// passes on the shared 1-D engine, then hands the block downstream.
module dct_block_seq import dct_pkg::*; #(
  parameter int N       = DCT_N,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  dct_block_seq_if.master  bus
);
  localparam int IW = $clog2(N);
  localparam int AW = 2 * IW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  state_t           state;
  logic [AW-1:0]    fill;
  logic [IW-1:0]    vec;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             accept, in_wait, in_issue, tmr_exp, timeout;

  assign in_wait  = (state == ROW_WAIT)  || (state == COL_WAIT);
  assign in_issue = (state == ROW_ISSUE) || (state == COL_ISSUE);

  // pix_ready is gated by rst so nothing is written while reset is held
  assign bus.pix_ready = ((state == IDLE) || (state == FILL)) && !rst;
  assign accept        = bus.pix_valid && bus.pix_ready;
  assign bus.buf_we    = accept;
  assign bus.buf_waddr = fill;
  assign bus.eng_start = in_issue;
  assign bus.eng_pass  = ((state == COL_ISSUE) || (state == COL_WAIT)) ? PASS_COL : PASS_ROW;
  assign bus.eng_idx   = vec;
  assign bus.blk_valid = (state == DRAIN);
  assign bus.blk_count = cnt;
  assign bus.err       = err_q;

  dct_wait_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (in_issue),
    .en      (in_wait),
    .expired (tmr_exp)
  );

  // A done landing on the expiry cycle still counts as a completed vector
  assign timeout = tmr_exp && !bus.eng_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fill  <= '0;
      vec   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (timeout)          err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;

      if (timeout) begin
        fill  <= '0;
        vec   <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            fill  <= AW'(1);
            state <= FILL;
          end
          FILL: if (accept) begin
            if (fill == LAST_ADDR) begin
              fill  <= '0;
              vec   <= '0;
              state <= ROW_ISSUE;
            end else begin
              fill <= fill + 1'b1;
            end
          end
          ROW_ISSUE: state <= ROW_WAIT;
          ROW_WAIT: if (bus.eng_done) begin
            if (vec == LAST_IDX) begin
              vec   <= '0;
              state <= COL_ISSUE;
            end else begin
              vec   <= vec + 1'b1;
              state <= ROW_ISSUE;
            end
          end
          COL_ISSUE: state <= COL_WAIT;
          COL_WAIT: if (bus.eng_done) begin
            if (vec == LAST_IDX) begin
              vec   <= '0;
              state <= DRAIN;
            end else begin
              vec   <= vec + 1'b1;
              state <= COL_ISSUE;
            end
          end
          DRAIN: if (bus.blk_ready) begin
            cnt   <= cnt + 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/dct_block_seq.md
Name: dct_block_seq

Overview:
- Sequencer for the 2-D DCT stage of the JPEG compressor.
- Accepts an 8-bit pixel stream in raster order and generates write addresses for the block buffer.
- Once a full NxN block is stored, it drives a shared 1-D DCT engine through N row passes and then N column passes.
- It then holds the finished coefficient block until the downstream quantiser accepts it. It carries no pixel data; control and addressing only.

Parameters:
- N, 8, block dimension; power of two, at least 2.
- TIMEOUT, 256, maximum cycles to wait for eng_done before abort.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- pix_valid  in  1  upstream pixel available.
- pix_ready  out  1  sequencer can take a pixel.
- buf_we  out  1  block buffer write strobe.
- buf_waddr  out  2*log2(N)  block buffer write address, raster index.
- eng_start  out  1  one-cycle start pulse to the 1-D DCT engine.
- eng_pass  out  1  0 = row pass, 1 = column pass.
- eng_idx  out  log2(N)  row or column index for the current vector.
- eng_done  in  1  engine finished the current vector; single-cycle pulse.
- blk_valid  out  1  coefficient block complete.
- blk_ready  in  1  downstream consumed the block.
- blk_count  out  CNT_W  count of completed blocks; wraps.
- err  out  1  sticky engine-timeout flag.
- err_clr  in  1  clears err.

Behaviour:
- States: IDLE, FILL, ROW_ISSUE, ROW_WAIT, COL_ISSUE, COL_WAIT, DRAIN.
- accept = pix_valid & pix_ready.
  - pix_ready = 1 only in IDLE or FILL, and is 0 while rst is high.
  - buf_we = accept, combinational.
  - buf_waddr = fill counter value.
- IDLE: the first accept writes address 0, sets fill counter to 1 and moves to FILL.
- FILL:
  - Each accept writes at the fill counter, then increments it.
  - An accept at address N*N-1 clears vec to 0 and moves to ROW_ISSUE on the next cycle; that cycle already shows pix_ready = 0.
  - A gap in pix_valid is a stall, not an abort.
- ROW_ISSUE: eng_start = 1 for exactly one cycle, eng_pass = 0, eng_idx = vec. Next state is ROW_WAIT and the wait counter is cleared.
- ROW_WAIT:
  - eng_idx and eng_pass stay stable.
  - On eng_done: if vec = N-1, clear vec to 0 and go to COL_ISSUE; otherwise increment vec and go to ROW_ISSUE.
  - eng_done arriving during an ISSUE state is ignored.
- COL_ISSUE and COL_WAIT: same as the row states with eng_pass = 1. After vec = N-1 completes, go to DRAIN.
- DRAIN:
  - blk_valid = 1 and held until blk_ready.
  - On blk_valid & blk_ready: blk_count increments (modulo 2^CNT_W) and the state returns to IDLE.
  - The next block's first pixel is accepted the cycle after.
- Timeout:
  - The wait counter increments every cycle in a WAIT state.
  - If it reaches TIMEOUT-1 without eng_done: err is set, vec and fill counter are cleared, and the state goes to IDLE. The partial block is discarded and blk_count is unchanged.
  - If eng_done and timeout expiry land on the same cycle, done wins.
- err_clr clears err. If err_clr and a timeout occur on the same cycle, the set wins.
- Reset values: state IDLE; all counters 0; eng_start, buf_we, blk_valid, err, eng_pass, eng_idx, buf_waddr all 0; blk_count 0.
- rst mid-block abandons the block with no eng_start and no blk_valid afterwards.
- Throughput with engine latency L cycles (start to done):
  - Minimum block period = N*N + 2*N*(L+1) + 1 cycles, with continuous pix_valid and blk_ready held at 1.
  - For N = 8, L = 4: 64 + 80 + 1 = 145 cycles.

Decomposition:
- Package dct_pkg holds:
  - State enum.
  - DCT_N = 8.
  - Derived widths IDX_W = log2(N) and ADDR_W = 2*IDX_W.
  - Pass encodings PASS_ROW = 0 and PASS_COL = 1.
- One natural sub-module, dct_wait_timer: cleared counter with an expired flag, parameterised by TIMEOUT.
- FSM, fill counter and vec counter live in the top module.

Test Plan:
- Nominal block:
  - Stimulus: 64 pixels with pix_valid held at 1; engine model returns done 4 cycles after start; blk_ready = 1.
  - Response: buf_waddr runs 0..63; eight eng_start pulses with pass 0 and idx 0..7, then eight with pass 1 and idx 0..7; blk_valid asserted once; blk_count = 1.
- Backpressure and stall:
  - Stimulus: pix_valid toggling 1010...; blk_ready held at 0 for 20 cycles in DRAIN.
  - Response: exactly 64 writes, no duplicates; blk_valid stays high for those 20 cycles; pix_ready = 0 throughout DRAIN.
- Timeout:
  - Stimulus: TIMEOUT = 16; engine never answers row 3.
  - Response: err = 1 exactly 16 cycles after that start (15 wait cycles); state IDLE; pix_ready = 1; blk_count unchanged.
  - Then: err_clr pulse gives err = 0; a following clean block completes normally.
- Done/expiry collision:
  - Stimulus: eng_done on the same cycle as wait counter = TIMEOUT-1.
  - Response: err stays 0 and the sequence continues to the next vector.
- Reset mid-operation:
  - Stimulus: rst asserted during COL_WAIT with idx 5.
  - Response: next cycle all outputs at reset values; no further eng_start until 64 new pixels are accepted.
- Counter wrap:
  - Stimulus: CNT_W = 2; run 5 blocks.
  - Response: blk_count sequence 1, 2, 3, 0, 1.
